// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - operation encodings presented on the mdu op port
//   - FSM state type
//   - default width and end-to-end latency (start edge to done edge)
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  // start sample edge through result edge, counted inclusively
  localparam int MDU_LAT   = MDU_WIDTH + 2;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_t;

endpackage

// File: rtl/mdu_negate.sv
// mdu_negate: conditional two's-complement of a WIDTH-bit value.
//   neg      : 1 = output ~din + carry_in, 0 = pass din through
//   carry_in : 1 for a plain negation; for the upper half of a wide
//              negation it is the borrow-free carry out of the lower half
//   din      : value in
//   dout     : value out
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Inverting and adding the carry gives the two's complement; chaining
  // two of these (upper carry_in = lower half is zero) negates a 2*WIDTH value.
  always_comb begin
    dout = din;
    if (neg) begin
      dout = ~din + {{(WIDTH-1){1'b0}}, carry_in};
    end
  end

endmodule

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit beside the EX stage.
//   clk, rst (sync, active-low)
//   start, op[1:0]   : launch MULTU/MULT/DIVU/DIV, sampled only in IDLE
//   a, b             : rs / rt operands (dividend / divisor for divides)
//   hi_we, lo_we,
//   wdata            : MTHI/MTLO writes, honoured only in IDLE
//   busy             : high while an operation is in flight (CALC, FIX)
//   done             : one-cycle pulse after HI/LO take a result
//   hi, lo           : architectural HI/LO registers
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_t         state, next_state;
  logic [CW-1:0]      count;
  logic               div_op;
  logic               res_neg;
  logic               rem_neg;
  logic               div_zero;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic               hi_neg, hi_carry;
  logic [WIDTH-1:0]   hi_res, lo_res;

  // Signed ops work on magnitudes; the signs are re-applied in FIX.
  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];

  mdu_negate #(.WIDTH(WIDTH)) u_neg_a (
    .neg(a_neg), .carry_in(1'b1), .din(a), .dout(mag_a_in)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_neg_b (
    .neg(b_neg), .carry_in(1'b1), .din(b), .dout(mag_b_in)
  );

  // One iteration of either datapath over the shared accumulator. Multiply
  // keeps {partial product, remaining multiplier bits} and shifts right;
  // divide keeps {partial remainder, dividend/quotient bits} and shifts left,
  // using the top WIDTH+1 bits as the restoring trial remainder.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mag_b};
    acc_next  = {mul_sum, acc[WIDTH-1:1]};
    if (div_op) begin
      if (div_diff[WIDTH]) begin
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end
  end

  // Result sign fix-up. For a product the two halves form one wide negation,
  // so the upper half only gets the +1 when the lower half was zero. For a
  // divide the halves are independent (remainder follows the dividend sign).
  always_comb begin
    hi_neg   = div_op ? rem_neg : res_neg;
    hi_carry = div_op ? 1'b1 : (acc[WIDTH-1:0] == '0);
  end

  mdu_negate #(.WIDTH(WIDTH)) u_neg_lo (
    .neg(res_neg), .carry_in(1'b1), .din(acc[WIDTH-1:0]), .dout(lo_res)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_neg_hi (
    .neg(hi_neg), .carry_in(hi_carry), .din(acc[2*WIDTH-1:WIDTH]), .dout(hi_res)
  );

  // State register; reset aborts anything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= MDU_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and busy. CALC leaves after the iteration at count zero,
  // FIX always lasts one cycle.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      MDU_IDLE: begin
        if (start) begin
          next_state = MDU_CALC;
        end
      end
      MDU_CALC: begin
        busy = 1'b1;
        if (count == '0) begin
          next_state = MDU_FIX;
        end
      end
      MDU_FIX: begin
        busy       = 1'b1;
        next_state = MDU_IDLE;
      end
      default: begin
        next_state = MDU_IDLE;
      end
    endcase
  end

  // Datapath registers. MT writes land only in IDLE and may share the cycle
  // with a launch; the result written in FIX overwrites both halves anyway.
  // Divide by zero naturally leaves the dividend as remainder, so only LO
  // needs forcing to all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      count    <= '0;
      acc      <= '0;
      mag_b    <= '0;
      div_op   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (hi_we) begin
            hi_q <= wdata;
          end
          if (lo_we) begin
            lo_q <= wdata;
          end
          if (start) begin
            div_op   <= op[1];
            acc      <= {{WIDTH{1'b0}}, mag_a_in};
            mag_b    <= mag_b_in;
            res_neg  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg  <= a_neg;
            div_zero <= op[1] & (b == '0);
            count    <= CW'(WIDTH - 1);
          end
        end
        MDU_CALC: begin
          acc <= acc_next;
          if (count != '0) begin
            count <= count - 1'b1;
          end
        end
        MDU_FIX: begin
          hi_q   <= hi_res;
          lo_q   <= div_zero ? '1 : lo_res;
          done_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed bench for the mdu with hand-computed HI/LO results,
// latency/busy-length checks, MT write gating, ignored restarts and reset abort.
module tb_mdu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int assert_count = 0;
  int fail_count   = 0;

  mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // 10-unit clock; all driving and sampling happens on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Launch one operation and follow it to completion. Optional extras:
  // an MTLO attempt during CALC, a second start sampled at E10, and an
  // MTHI landing in the same cycle as the launch.
  task automatic applyStimulus(input string tag, input logic [1:0] o,
                               input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input bit mt_calc, input bit restart, input bit mt_start);
    int          cycles;
    int          busy_cnt;
    bit          hold_ok;
    logic [31:0] old_hi, old_lo;
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    if (mt_start) begin
      hi_we = 1'b1;
      wdata = 32'hBEEF;
    end
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
    if (mt_start) begin
      checkOutput({tag, " mthi with start"}, {32'h0, hi}, {32'h0, 32'hBEEF});
    end
    old_hi   = hi;
    old_lo   = lo;
    hold_ok  = 1'b1;
    cycles   = 0;
    busy_cnt = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      if (hi !== old_hi || lo !== old_lo) hold_ok = 1'b0;
      if (mt_calc && cycles == 5) begin
        lo_we = 1'b1;
        wdata = 32'h5555;
      end
      if (mt_calc && cycles == 6) lo_we = 1'b0;
      if (restart && cycles == 9) start = 1'b1;
      if (restart && cycles == 10) start = 1'b0;
      @(negedge clk);
      cycles++;
    end
    lo_we = 1'b0;
    start = 1'b0;
    // Start sampled at E0, done visible after E33: 33 falling edges later.
    checkOutput({tag, " done seen"}, {63'h0, done}, 64'h1);
    checkOutput({tag, " latency"}, 64'(cycles), 64'd33);
    checkOutput({tag, " busy cycles"}, 64'(busy_cnt), 64'd33);
    checkOutput({tag, " hold during calc"}, {63'h0, hold_ok}, 64'h1);
    checkOutput({tag, " busy at done"}, {63'h0, busy}, 64'h0);
    checkOutput({tag, " hi"}, {32'h0, hi}, {32'h0, exp_hi});
    checkOutput({tag, " lo"}, {32'h0, lo}, {32'h0, exp_lo});
    @(negedge clk);
    checkOutput({tag, " done pulse width"}, {63'h0, done}, 64'h0);
    checkOutput({tag, " idle after"}, {63'h0, busy}, 64'h0);
  endtask

  initial begin
    int done_cnt;
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'h0;
    b     = 32'h0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset hi", {32'h0, hi}, 64'h0);
    checkOutput("reset lo", {32'h0, lo}, 64'h0);
    checkOutput("reset busy", {63'h0, busy}, 64'h0);
    checkOutput("reset done", {63'h0, done}, 64'h0);
    rst = 1'b1;
    @(negedge clk);

    // MTHI in IDLE lands at the next edge; LO untouched
    hi_we = 1'b1;
    wdata = 32'hAAAA;
    @(negedge clk);
    hi_we = 1'b0;
    checkOutput("mthi idle hi", {32'h0, hi}, {32'h0, 32'hAAAA});
    checkOutput("mthi idle lo", {32'h0, lo}, 64'h0);

    applyStimulus("multu max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b0);
    applyStimulus("mult -7*6", 2'b01, 32'hFFFFFFF9, 32'h00000006,
                  32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 1'b0, 1'b1);
    applyStimulus("mult min*min", 2'b01, 32'h80000000, 32'h80000000,
                  32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
    applyStimulus("div -7/2", 2'b11, 32'hFFFFFFF9, 32'h00000002,
                  32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
    applyStimulus("div 7/-2", 2'b11, 32'h00000007, 32'hFFFFFFFE,
                  32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
    applyStimulus("divu 100/7", 2'b10, 32'd100, 32'd7,
                  32'd2, 32'd14, 1'b1, 1'b1, 1'b0);
    applyStimulus("divu by zero", 2'b10, 32'h00001234, 32'h0,
                  32'h00001234, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus("div neg by zero", 2'b11, 32'hFFFFFFF9, 32'h0,
                  32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus("div min/-1", 2'b11, 32'h80000000, 32'hFFFFFFFF,
                  32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a MULT: result discarded, no done pulse
    op    = 2'b01;
    a     = 32'h00000003;
    b     = 32'h00000005;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort hi", {32'h0, hi}, 64'h0);
    checkOutput("abort lo", {32'h0, lo}, 64'h0);
    checkOutput("abort busy", {63'h0, busy}, 64'h0);
    checkOutput("abort done", {63'h0, done}, 64'h0);
    rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    checkOutput("abort no done", 64'(done_cnt), 64'h0);

    applyStimulus("mult after reset", 2'b01, 32'h00000003, 32'hFFFFFFFB,
                  32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
